// File: rtl/regfile_sb_if.sv
// Register-file / scoreboard bus between the core pipeline and regfile_sb.
// master: decode/execute + LSU side; slave: the register file.
interface regfile_sb_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2
);
    localparam int unsigned AW = $clog2(NREG);

    // read ports
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    // core write sources
    logic                alu_we;
    logic                lui_we;
    logic                jal_we;
    logic [AW-1:0]       wr_rd;
    logic [XLEN-1:0]     alu_data;
    logic [XLEN-1:0]     imm_val_lui;
    logic [XLEN-1:0]     return_addr;
    logic                wb_hold;
    // load scoreboard
    logic                ld_issue;
    logic [AW-1:0]       ld_rd;
    logic                ld_issue_rdy;
    logic                ld_rsp_valid;
    logic [AW-1:0]       ld_rsp_rd;
    logic [XLEN-1:0]     ld_rsp_data;
    // store data port
    logic                st_req;
    logic [AW-1:0]       st_rs;
    logic                st_ready;
    logic                st_valid;
    logic [XLEN-1:0]     st_data;
    logic                st_ack;

    modport master (
        output rd_addr, alu_we, lui_we, jal_we, wr_rd, alu_data, imm_val_lui, return_addr,
               ld_issue, ld_rd, ld_rsp_valid, ld_rsp_rd, ld_rsp_data, st_req, st_rs, st_ack,
        input  rd_data, rd_busy, wb_hold, ld_issue_rdy, st_ready, st_valid, st_data
    );

    modport slave (
        input  rd_addr, alu_we, lui_we, jal_we, wr_rd, alu_data, imm_val_lui, return_addr,
               ld_issue, ld_rd, ld_rsp_valid, ld_rsp_rd, ld_rsp_data, st_req, st_rs, st_ack,
        output rd_data, rd_busy, wb_hold, ld_issue_rdy, st_ready, st_valid, st_data
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with load scoreboard and registered store-data port.
// Single arbitrated write port: load response > JAL > LUI > ALU. x0 reads zero.
// Optional macro REGFILE_BYPASS_EN: read ports and store capture forward the
// winning same-cycle write (write-first); otherwise reads are read-first.
module regfile_sb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned NRD  = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    regfile_sb_if.slave  bus
);
    localparam int unsigned AW = $clog2(NREG);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic            st_valid_q;
    logic [XLEN-1:0] st_data_q;

    logic            rsp_ok;
    logic            core_we;
    logic            win_we;
    logic [AW-1:0]   win_idx;
    logic [XLEN-1:0] win_data;
    logic            issue_take;
    logic            st_take;
    logic [XLEN-1:0] st_src;

    // Write-port arbitration; a stray response (busy clear) never wins
    always_comb begin
        rsp_ok   = bus.ld_rsp_valid & busy[bus.ld_rsp_rd];
        core_we  = bus.alu_we | bus.lui_we | bus.jal_we;
        win_we   = 1'b0;
        win_idx  = '0;
        win_data = '0;
        if (rsp_ok) begin
            win_we   = 1'b1;
            win_idx  = bus.ld_rsp_rd;
            win_data = bus.ld_rsp_data;
        end else if (bus.jal_we) begin
            win_we   = 1'b1;
            win_idx  = bus.wr_rd;
            win_data = bus.return_addr;
        end else if (bus.lui_we) begin
            win_we   = 1'b1;
            win_idx  = bus.wr_rd;
            win_data = bus.imm_val_lui;
        end else if (bus.alu_we) begin
            win_we   = 1'b1;
            win_idx  = bus.wr_rd;
            win_data = bus.alu_data;
        end
        if (win_idx == '0) begin
            win_we = 1'b0;
        end
    end

    assign bus.wb_hold      = core_we & rsp_ok;
    assign bus.ld_issue_rdy = ~busy[bus.ld_rd];
    assign issue_take       = bus.ld_issue & ~busy[bus.ld_rd] & (bus.ld_rd != '0);

    // Combinational read ports
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] val;
        assign idx = bus.rd_addr[k*AW +: AW];
        // Per-port read value, x0 forced to zero
        always_comb begin
            val = regs[idx];
            if (idx == '0) begin
                val = '0;
            end
`ifdef REGFILE_BYPASS_EN
            if (win_we && (win_idx == idx)) begin
                val = win_data;
            end
`endif
        end
        assign bus.rd_data[k*XLEN +: XLEN] = val;
        assign bus.rd_busy[k]              = busy[idx];
    end

    // Store-source read, same forwarding rule as the read ports
    always_comb begin
        st_src = regs[bus.st_rs];
        if (bus.st_rs == '0) begin
            st_src = '0;
        end
`ifdef REGFILE_BYPASS_EN
        if (win_we && (win_idx == bus.st_rs)) begin
            st_src = win_data;
        end
`endif
    end

    assign bus.st_ready = ~st_valid_q | bus.st_ack;
    assign st_take      = bus.st_req & bus.st_ready;
    assign bus.st_valid = st_valid_q;
    assign bus.st_data  = st_data_q;

    // Register array update
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (win_we) begin
            regs[win_idx] <= win_data;
        end
    end

    // Load scoreboard: issue and response never target the same register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            if (rsp_ok) begin
                busy[bus.ld_rsp_rd] <= 1'b0;
            end
            if (issue_take) begin
                busy[bus.ld_rd] <= 1'b1;
            end
        end
    end

    // Store-data holding register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st_valid_q <= 1'b0;
            st_data_q  <= '0;
        end else if (st_take) begin
            st_valid_q <= 1'b1;
            st_data_q  <= st_src;
        end else if (bus.st_ack) begin
            st_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Testbench for regfile_sb: directed scenarios plus randomized traffic checked
// against an array-based reference model. Honors REGFILE_BYPASS_EN.
module tb_regfile_sb;
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned NRD  = 2;
    localparam int unsigned AW   = 5;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();
    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // reference model state
    logic [31:0] mreg [32];
    logic [31:0] mbusy;
    logic        m_stv;
    logic [31:0] m_std;

    int tests = 0;
    int fails = 0;

    // Winning write this cycle, from the priority rules
    function automatic void model_win(output logic we, output logic [4:0] idx, output logic [31:0] d);
        we = 1'b0; idx = '0; d = '0;
        if (bus.ld_rsp_valid && mbusy[bus.ld_rsp_rd]) begin
            we = 1'b1; idx = bus.ld_rsp_rd; d = bus.ld_rsp_data;
        end else if (bus.jal_we) begin
            we = 1'b1; idx = bus.wr_rd; d = bus.return_addr;
        end else if (bus.lui_we) begin
            we = 1'b1; idx = bus.wr_rd; d = bus.imm_val_lui;
        end else if (bus.alu_we) begin
            we = 1'b1; idx = bus.wr_rd; d = bus.alu_data;
        end
        if (idx == 5'd0) we = 1'b0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
`ifdef REGFILE_BYPASS_EN
        logic        we;
        logic [4:0]  wi;
        logic [31:0] wd;
        model_win(we, wi, wd);
        if (we && wi == idx && idx != 5'd0) return wd;
`endif
        if (idx == 5'd0) return 32'd0;
        return mreg[idx];
    endfunction

    function automatic logic exp_hold();
        return (bus.alu_we || bus.lui_we || bus.jal_we) && bus.ld_rsp_valid && mbusy[bus.ld_rsp_rd];
    endfunction

    task automatic idle();
        bus.rd_addr = '0; bus.alu_we = 1'b0; bus.lui_we = 1'b0; bus.jal_we = 1'b0;
        bus.wr_rd = '0; bus.alu_data = '0; bus.imm_val_lui = '0; bus.return_addr = '0;
        bus.ld_issue = 1'b0; bus.ld_rd = '0; bus.ld_rsp_valid = 1'b0; bus.ld_rsp_rd = '0;
        bus.ld_rsp_data = '0; bus.st_req = 1'b0; bus.st_rs = '0; bus.st_ack = 1'b0;
    endtask

    // Advance one clock: compute model next state from current inputs, then apply at the edge
    task automatic cycle();
        logic        we;
        logic [4:0]  wi;
        logic [31:0] wd;
        logic        stv_n;
        logic [31:0] std_n;
        logic [31:0] busy_n;
        model_win(we, wi, wd);
        stv_n = m_stv; std_n = m_std;
        if (bus.st_req && (!m_stv || bus.st_ack)) begin
            stv_n = 1'b1; std_n = exp_read(bus.st_rs);
        end else if (bus.st_ack) begin
            stv_n = 1'b0;
        end
        busy_n = mbusy;
        if (bus.ld_rsp_valid && mbusy[bus.ld_rsp_rd]) busy_n[bus.ld_rsp_rd] = 1'b0;
        if (bus.ld_issue && !mbusy[bus.ld_rd] && bus.ld_rd != 5'd0) busy_n[bus.ld_rd] = 1'b1;
        @(posedge clk);
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mreg[i] = '0;
            mbusy = '0; m_stv = 1'b0; m_std = '0;
        end else begin
            if (we) mreg[wi] = wd;
            mbusy = busy_n; m_stv = stv_n; m_std = std_n;
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr = {AW'(i), AW'(i)};
            #1;
            tests++;
            if (bus.rd_data !== 64'd0 || bus.rd_busy !== 2'b00) begin
                fails++;
                $display("FAIL reset_read idx %0d got data %h busy %b exp 0", i, bus.rd_data, bus.rd_busy);
            end
        end
        tests++;
        if (bus.st_valid !== 1'b0 || bus.st_data !== 32'd0) begin
            fails++;
            $display("FAIL reset_store got valid %b data %h exp 0", bus.st_valid, bus.st_data);
        end
        idle();
    endtask

    task automatic test_alu_write();
        bus.alu_we = 1'b1; bus.wr_rd = 5'd5; bus.alu_data = 32'h1;
        cycle(); idle();
        bus.rd_addr = {5'd0, 5'd5};
        #1; tests++;
        if (bus.rd_data[31:0] !== 32'h1) begin
            fails++; $display("FAIL alu_write5 got %h exp 00000001", bus.rd_data[31:0]);
        end
        bus.alu_we = 1'b1; bus.wr_rd = 5'd0; bus.alu_data = 32'hFFFF;
        cycle(); idle();
        bus.rd_addr = {5'd0, 5'd0};
        #1; tests++;
        if (bus.rd_data[31:0] !== 32'h0) begin
            fails++; $display("FAIL write_x0 got %h exp 00000000", bus.rd_data[31:0]);
        end
    endtask

    task automatic test_load();
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd7;
        cycle(); idle();
        bus.rd_addr = {5'd0, 5'd7}; bus.ld_rd = 5'd7;
        #1; tests++;
        if (bus.rd_busy[0] !== 1'b1 || bus.ld_issue_rdy !== 1'b0) begin
            fails++; $display("FAIL load_busy got busy %b rdy %b exp 1 0", bus.rd_busy[0], bus.ld_issue_rdy);
        end
        bus.ld_rsp_valid = 1'b1; bus.ld_rsp_rd = 5'd7; bus.ld_rsp_data = 32'h25;
        cycle(); idle();
        bus.rd_addr = {5'd0, 5'd7}; bus.ld_rd = 5'd7;
        #1; tests++;
        if (bus.rd_busy[0] !== 1'b0 || bus.rd_data[31:0] !== 32'h25 || bus.ld_issue_rdy !== 1'b1) begin
            fails++; $display("FAIL load_return got busy %b data %h rdy %b exp 0 00000025 1",
                              bus.rd_busy[0], bus.rd_data[31:0], bus.ld_issue_rdy);
        end
    endtask

    task automatic test_wb_hold();
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd6;
        cycle(); idle();
        bus.ld_rsp_valid = 1'b1; bus.ld_rsp_rd = 5'd6; bus.ld_rsp_data = 32'h49;
        bus.alu_we = 1'b1; bus.wr_rd = 5'd6; bus.alu_data = 32'h33;
        #1; tests++;
        if (bus.wb_hold !== 1'b1) begin
            fails++; $display("FAIL wb_hold_set got %b exp 1", bus.wb_hold);
        end
        cycle(); idle();
        bus.rd_addr = {5'd0, 5'd6};
        #1; tests++;
        if (bus.rd_data[31:0] !== 32'h49) begin
            fails++; $display("FAIL wb_load_wins got %h exp 00000049", bus.rd_data[31:0]);
        end
        bus.alu_we = 1'b1; bus.wr_rd = 5'd6; bus.alu_data = 32'h33;
        #1; tests++;
        if (bus.wb_hold !== 1'b0) begin
            fails++; $display("FAIL wb_hold_clear got %b exp 0", bus.wb_hold);
        end
        cycle(); idle();
        bus.rd_addr = {5'd0, 5'd6};
        #1; tests++;
        if (bus.rd_data[31:0] !== 32'h33) begin
            fails++; $display("FAIL wb_represent got %h exp 00000033", bus.rd_data[31:0]);
        end
        bus.alu_we = 1'b1; bus.wr_rd = 5'd6; bus.alu_data = 32'h49;
        cycle(); idle();
    endtask

    task automatic test_store();
        bus.st_req = 1'b1; bus.st_rs = 5'd6;
        #1; tests++;
        if (bus.st_ready !== 1'b1) begin
            fails++; $display("FAIL st_ready_idle got %b exp 1", bus.st_ready);
        end
        cycle(); idle();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bus.st_valid !== 1'b1 || bus.st_data !== 32'h49 || bus.st_ready !== 1'b0) begin
                fails++; $display("FAIL st_hold cyc %0d got v %b d %h rdy %b exp 1 00000049 0",
                                  i, bus.st_valid, bus.st_data, bus.st_ready);
            end
            if (i < 3) cycle();
        end
        bus.st_ack = 1'b1; bus.st_req = 1'b1; bus.st_rs = 5'd5;
        #1; tests++;
        if (bus.st_ready !== 1'b1) begin
            fails++; $display("FAIL st_ready_ack got %b exp 1", bus.st_ready);
        end
        cycle(); idle();
        tests++;
        if (bus.st_valid !== 1'b1 || bus.st_data !== 32'h1) begin
            fails++; $display("FAIL st_b2b got v %b d %h exp 1 00000001", bus.st_valid, bus.st_data);
        end
        bus.st_req = 1'b1; bus.st_rs = 5'd6;
        cycle(); idle();
        tests++;
        if (bus.st_valid !== 1'b1 || bus.st_data !== 32'h1) begin
            fails++; $display("FAIL st_req_ignored got v %b d %h exp 1 00000001", bus.st_valid, bus.st_data);
        end
        bus.st_ack = 1'b1;
        cycle(); idle();
        tests++;
        if (bus.st_valid !== 1'b0) begin
            fails++; $display("FAIL st_ack_clear got %b exp 0", bus.st_valid);
        end
    endtask

    task automatic test_reset_midflight();
        bus.ld_issue = 1'b1; bus.ld_rd = 5'd9;
        cycle(); idle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        bus.ld_rsp_valid = 1'b1; bus.ld_rsp_rd = 5'd9; bus.ld_rsp_data = 32'hAA;
        cycle(); idle();
        bus.rd_addr = {5'd9, 5'd9};
        #1; tests++;
        if (bus.rd_data[31:0] !== 32'h0 || bus.rd_busy !== 2'b00) begin
            fails++; $display("FAIL stray_rsp got data %h busy %b exp 0 00", bus.rd_data[31:0], bus.rd_busy);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_v;
`ifdef REGFILE_BYPASS_EN
        exp_v = 32'h1234;
`else
        exp_v = 32'h0;
`endif
        bus.alu_we = 1'b1; bus.wr_rd = 5'd10; bus.alu_data = 32'h1234;
        bus.rd_addr = {5'd10, 5'd10}; bus.st_req = 1'b1; bus.st_rs = 5'd10;
        #1; tests++;
        if (bus.rd_data[63:32] !== exp_v) begin
            fails++; $display("FAIL same_cycle_read got %h exp %h", bus.rd_data[63:32], exp_v);
        end
        cycle(); idle();
        bus.rd_addr = {5'd10, 5'd0};
        #1; tests++;
        if (bus.st_data !== exp_v || bus.rd_data[63:32] !== 32'h1234) begin
            fails++; $display("FAIL same_cycle_store got st %h rd %h exp %h 00001234",
                              bus.st_data, bus.rd_data[63:32], exp_v);
        end
        bus.alu_we = 1'b1; bus.wr_rd = 5'd0; bus.alu_data = 32'h5; bus.rd_addr = {5'd0, 5'd0};
        bus.st_ack = 1'b1;
        #1; tests++;
        if (bus.rd_data !== 64'd0) begin
            fails++; $display("FAIL x0_no_forward got %h exp 0", bus.rd_data);
        end
        cycle(); idle();
    endtask

    task automatic test_random();
        logic [4:0] a0, a1;
        for (int c = 0; c < 400; c++) begin
            reset_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            a0 = 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 7));
            bus.rd_addr      = {a1, a0};
            bus.alu_we       = 1'($urandom_range(0, 1));
            bus.lui_we       = ($urandom_range(0, 3) == 0);
            bus.jal_we       = ($urandom_range(0, 3) == 0);
            bus.wr_rd        = 5'($urandom_range(0, 7));
            bus.alu_data     = $urandom;
            bus.imm_val_lui  = $urandom & 32'hFFFF_F000;
            bus.return_addr  = $urandom & 32'hFFFF_FFFC;
            bus.ld_issue     = 1'($urandom_range(0, 1));
            bus.ld_rd        = 5'($urandom_range(0, 7));
            bus.ld_rsp_valid = ($urandom_range(0, 9) < 4);
            bus.ld_rsp_rd    = 5'($urandom_range(0, 7));
            bus.ld_rsp_data  = $urandom;
            bus.st_req       = 1'($urandom_range(0, 1));
            bus.st_rs        = 5'($urandom_range(0, 7));
            bus.st_ack       = 1'($urandom_range(0, 1));
            #1;
            tests++;
            if (bus.rd_data[31:0] !== exp_read(a0) || bus.rd_data[63:32] !== exp_read(a1)) begin
                fails++; $display("FAIL rand_read cyc %0d got %h exp %h_%h", c, bus.rd_data,
                                  exp_read(a1), exp_read(a0));
            end
            tests++;
            if (bus.rd_busy !== {mbusy[a1], mbusy[a0]} || bus.ld_issue_rdy !== !mbusy[bus.ld_rd]) begin
                fails++; $display("FAIL rand_busy cyc %0d got %b rdy %b exp %b rdy %b", c, bus.rd_busy,
                                  bus.ld_issue_rdy, {mbusy[a1], mbusy[a0]}, !mbusy[bus.ld_rd]);
            end
            tests++;
            if (bus.wb_hold !== exp_hold()) begin
                fails++; $display("FAIL rand_hold cyc %0d got %b exp %b", c, bus.wb_hold, exp_hold());
            end
            tests++;
            if (bus.st_valid !== m_stv || bus.st_data !== m_std || bus.st_ready !== (!m_stv || bus.st_ack)) begin
                fails++; $display("FAIL rand_store cyc %0d got v %b d %h r %b exp v %b d %h r %b", c,
                                  bus.st_valid, bus.st_data, bus.st_ready, m_stv, m_std, (!m_stv || bus.st_ack));
            end
            cycle();
        end
        reset_n = 1'b1;
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        idle();
        test_reset();
        test_alu_write();
        test_load();
        test_wb_hold();
        test_store();
        test_reset_midflight();
        test_same_cycle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
